// File: rtl/ddr_arb_pkg.sv
// ddr_write_arbiter shared types: FSM states, widths, round-robin helper.
// Optional build macro: DDR_WR_ARB_TIMEOUT_EN (see ddr_write_arbiter.sv).
package ddr_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    REQ,
    BURST,
    DONE
  } state_e;

  localparam int C_ADDR_WIDTH = 32;
  localparam int C_MAX_REQ    = 4;
  localparam int C_IDX_WIDTH  = 2;
  localparam int C_CNT_WIDTH  = 16;

  function automatic logic [C_IDX_WIDTH-1:0] rr_next(
    input logic [C_IDX_WIDTH-1:0] idx,
    input int                     n
  );
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/ddr_write_arbiter_rr_priority_picker.sv
// Combinational round-robin select: first set request at/after pointer.
// Returns one-hot grant, its index and a valid flag.
module rr_priority_picker
  import ddr_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]           req_i,
  input  logic [C_IDX_WIDTH-1:0] ptr_i,
  output logic [N-1:0]           gnt_o,
  output logic [C_IDX_WIDTH-1:0] idx_o,
  output logic                   valid_o
);

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
        idx_o   = C_IDX_WIDTH'((int'(ptr_i) + i) % N);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_write_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one DDR write master.
// DDR_WR_ARB_TIMEOUT_EN adds a BURST watchdog that aborts with err_o.
module ddr_write_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int g_NUM_REQ        = 2,
  parameter int g_DATA_WIDTH     = 64,
  parameter int g_LEN_WIDTH      = 8,
  parameter int g_TIMEOUT_CYCLES = 4096
) (
  input  logic                                sys_clk_i,
  input  logic                                reset_i,
  input  logic [g_NUM_REQ-1:0]                req_i,
  input  logic [g_NUM_REQ*C_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [g_NUM_REQ*g_LEN_WIDTH-1:0]    req_len_i,
  input  logic [g_NUM_REQ*g_DATA_WIDTH-1:0]   req_data_i,
  output logic [g_NUM_REQ-1:0]                ack_o,
  output logic [g_NUM_REQ-1:0]                done_o,
  output logic [g_NUM_REQ-1:0]                err_o,
  output logic [g_NUM_REQ-1:0]                data_rd_o,
  output logic [C_IDX_WIDTH-1:0]              grant_idx_o,
  output logic                                busy_o,
  output logic                                write_req_o,
  output logic [C_ADDR_WIDTH-1:0]             write_start_addr_o,
  output logic [g_LEN_WIDTH-1:0]              write_length_o,
  output logic [g_DATA_WIDTH-1:0]             wdata_o,
  input  logic                                wdata_rd_i,
  input  logic                                write_ackn_i,
  input  logic                                write_done_i
);

  localparam int N = g_NUM_REQ;

  if (N < 2 || N > C_MAX_REQ ||
      g_TIMEOUT_CYCLES < 1 ||
      g_TIMEOUT_CYCLES > (1 << C_CNT_WIDTH)) begin : g_bad_cfg
    $error("ddr_write_arbiter: unsupported parameters");
  end

  state_e                   state_q, state_d;
  logic [C_IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [C_IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [N-1:0]             gnt_q, gnt_d;
  logic [C_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [g_LEN_WIDTH-1:0]   len_q, len_d;
  logic                     ack_q, ack_d;

  logic [C_ADDR_WIDTH-1:0]  addr_a [C_MAX_REQ];
  logic [g_LEN_WIDTH-1:0]   len_a  [C_MAX_REQ];
  logic [g_DATA_WIDTH-1:0]  data_a [C_MAX_REQ];

  logic [N-1:0]             pick_gnt;
  logic [C_IDX_WIDTH-1:0]   pick_idx;
  logic                     pick_valid;
  logic                     xfer;

  // Pad to C_MAX_REQ so a 2-bit index never selects out of range.
  for (genvar i = 0; i < C_MAX_REQ; i++) begin : g_unpack
    if (i < N) begin : g_on
      assign addr_a[i] = req_addr_i[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
      assign len_a[i]  = req_len_i[i*g_LEN_WIDTH +: g_LEN_WIDTH];
      assign data_a[i] = req_data_i[i*g_DATA_WIDTH +: g_DATA_WIDTH];
    end else begin : g_off
      assign addr_a[i] = '0;
      assign len_a[i]  = '0;
      assign data_a[i] = '0;
    end
  end

  rr_priority_picker #(
    .N (N)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

`ifdef DDR_WR_ARB_TIMEOUT_EN
  localparam logic [C_CNT_WIDTH-1:0] C_TO_LAST =
    C_CNT_WIDTH'(g_TIMEOUT_CYCLES - 1);

  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;

  // Runs only in BURST, so it reads zero on BURST entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == BURST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = {N{err_q}} & gnt_q;
`else
  assign err_o = '0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    ack_d   = 1'b0;
`ifdef DDR_WR_ARB_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_i) state_d = ARB;
      end
      ARB: begin
        if (pick_valid) begin
          idx_d  = pick_idx;
          gnt_d  = pick_gnt;
          addr_d = addr_a[pick_idx];
          len_d  = len_a[pick_idx];
          // Empty burst: acknowledge and finish without the master.
          if (len_a[pick_idx] == '0) begin
            ack_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (write_ackn_i) begin
          ack_d   = 1'b1;
          state_d = write_done_i ? DONE : BURST;
        end
      end
      BURST: begin
        if (write_done_i) begin
          state_d = DONE;
`ifdef DDR_WR_ARB_TIMEOUT_EN
        end else if (cnt_q == C_TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        ptr_d   = rr_next(idx_q, N);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      ack_q   <= ack_d;
    end
  end

  assign xfer = (state_q == REQ) || (state_q == BURST);

  assign ack_o              = {N{ack_q}} & gnt_q;
  assign done_o             = {N{state_q == DONE}} & gnt_q;
  assign data_rd_o          = {N{xfer & wdata_rd_i}} & gnt_q;
  assign grant_idx_o        = idx_q;
  assign busy_o             = state_q != IDLE;
  assign write_req_o        = state_q == REQ;
  assign write_start_addr_o = addr_q;
  assign write_length_o     = len_q;
  assign wdata_o            = xfer ? data_a[idx_q] : '0;

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// Self-checking bench for ddr_write_arbiter (2 requesters).
// Scoreboard of expected grants; a bench-side DDR master answers.
module tb_ddr_write_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int LW = 8;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] addr;
    logic [7:0]  len;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*32-1:0]   req_addr;
  logic [N*LW-1:0]   req_len;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      ack, done, err, data_rd;
  logic [1:0]        grant_idx;
  logic              busy, write_req;
  logic [31:0]       write_addr;
  logic [LW-1:0]     write_len;
  logic [DW-1:0]     wdata;
  logic              wdata_rd, write_ackn, write_done;

  logic [31:0]       addr_tab [N];
  logic [LW-1:0]     len_tab  [N];
  logic [DW-1:0]     data_tab [N];

  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;

  assign req_addr = {addr_tab[1], addr_tab[0]};
  assign req_len  = {len_tab[1], len_tab[0]};
  assign req_data = {data_tab[1], data_tab[0]};

  always #5 clk = ~clk;

  ddr_write_arbiter #(
    .g_NUM_REQ        (N),
    .g_DATA_WIDTH     (DW),
    .g_LEN_WIDTH      (LW),
    .g_TIMEOUT_CYCLES (64)
  ) dut (
    .sys_clk_i          (clk),
    .reset_i            (rst_n),
    .req_i              (req),
    .req_addr_i         (req_addr),
    .req_len_i          (req_len),
    .req_data_i         (req_data),
    .ack_o              (ack),
    .done_o             (done),
    .err_o              (err),
    .data_rd_o          (data_rd),
    .grant_idx_o        (grant_idx),
    .busy_o             (busy),
    .write_req_o        (write_req),
    .write_start_addr_o (write_addr),
    .write_length_o     (write_len),
    .wdata_o            (wdata),
    .wdata_rd_i         (wdata_rd),
    .write_ackn_i       (write_ackn),
    .write_done_i       (write_done)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input logic [1:0] i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic void push(input int i);
    exp_t e;
    e.idx  = 2'(i);
    e.addr = addr_tab[i];
    e.len  = len_tab[i];
    sb.push_back(e);
  endfunction

  // Wait for write_req_o, compare with the scoreboard head, then accept.
  task automatic start_burst(output exp_t e, input int ack_dly,
                             input bit hold);
    int n;
    logic [31:0] keep;
    n = 0;
    e = '{default: '0};
    while (!write_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("write_req_seen", write_req, 1);
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) e = sb.pop_front();
    chk("grant_idx", grant_idx, e.idx);
    chk("start_addr", write_addr, e.addr);
    chk("length", write_len, e.len);
    chk("busy_req", busy, 1);
    for (int k = 1; k < ack_dly; k++) begin
      @(negedge clk);
      chk("write_req_hold", write_req, 1);
    end
    write_ackn = 1'b1;
    @(negedge clk);
    write_ackn = 1'b0;
    chk("ack_o", ack, oh(e.idx));
    chk("write_req_drop", write_req, 0);
    if (!hold) req[e.idx] = 1'b0;
    keep = addr_tab[e.idx];
    addr_tab[e.idx] = keep ^ 32'h00FF_FF00;
    #1;
    chk("addr_latched", write_addr, e.addr);
    addr_tab[e.idx] = keep;
  endtask

  task automatic serve(input int ack_dly, input int beats,
                       input int done_dly, input bit hold);
    exp_t e;
    start_burst(e, ack_dly, hold);
    @(negedge clk);
    chk("ack_single", ack, 0);
    for (int b = 0; b < beats; b++) begin
      wdata_rd = 1'b1;
      #1;
      chk("data_rd", data_rd, oh(e.idx));
      chk("wdata", wdata, data_tab[e.idx]);
      @(negedge clk);
      wdata_rd = 1'b0;
    end
    repeat (done_dly) @(negedge clk);
    chk("no_early_done", done, 0);
    write_done = 1'b1;
    @(negedge clk);
    write_done = 1'b0;
    chk("done_o", done, oh(e.idx));
    chk("err_o_clean", err, 0);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic zero_len(input int i);
    exp_t e;
    int   n;
    int   nreq;
    e = '{default: '0};
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) e = sb.pop_front();
    n    = 0;
    nreq = 0;
    while (!done[i] && n < 10) begin
      @(negedge clk);
      if (write_req) nreq++;
      n++;
    end
    chk("z_done", done, oh(e.idx));
    chk("z_ack", ack, oh(e.idx));
    chk("z_grant", grant_idx, e.idx);
    chk("z_no_write_req", nreq, 0);
    req[i] = 1'b0;
    @(negedge clk);
    chk("z_done_single", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;
    rst_n      = 1'b0;
    req        = '0;
    wdata_rd   = 1'b0;
    write_ackn = 1'b0;
    write_done = 1'b0;
    addr_tab[0] = 32'h1000_0000;
    addr_tab[1] = 32'h2000_0040;
    len_tab[0]  = 8'd15;
    len_tab[1]  = 8'd7;
    data_tab[0] = 64'hA0A0_0000_1111_0000;
    data_tab[1] = 64'hB1B1_0000_2222_0001;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_write_req", write_req, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_outs", {ack, done, err, data_rd}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester 0, ack after 3 cycles, done 20 later.
    req[0] = 1'b1;
    push(0);
    @(negedge clk);
    chk("latency_arb", write_req, 0);
    serve(3, 4, 20, 0);

    // Requester 1, zero length: no master request.
    len_tab[1] = 8'd0;
    req[1] = 1'b1;
    push(1);
    zero_len(1);
    len_tab[1] = 8'd7;

    // Both held: alternate 0,1,0,1.
    push(0);
    push(1);
    push(0);
    push(1);
    req = 2'b11;
    repeat (4) serve(1, 1, 2, 1);
    req = 2'b00;
    @(negedge clk);

    // Strobes while idle are dropped; then a 16-beat burst for 1.
    wdata_rd = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_data_rd", data_rd, 0);
    end
    wdata_rd = 1'b0;
    req[1] = 1'b1;
    push(1);
    serve(1, 16, 2, 0);

    // Pointer moves to 1, then reset mid-burst restarts at 0.
    req[0] = 1'b1;
    push(0);
    serve(1, 1, 1, 0);
    req[0] = 1'b1;
    push(0);
    start_burst(e, 1, 0);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ctl", {write_req, ack, done, err, data_rd}, 0);
    chk("mid_rst_addr", write_addr, 0);
    chk("mid_rst_len", write_len, 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_grant", grant_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    req = 2'b11;
    push(0);
    push(1);
    serve(2, 2, 3, 0);
    serve(1, 0, 1, 0);

`ifdef DDR_WR_ARB_TIMEOUT_EN
    // No write_done_i: watchdog aborts after 64 BURST cycles.
    req[0] = 1'b1;
    push(0);
    start_burst(e, 1, 0);
    n = 0;
    while (!done[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, 64);
    chk("to_done", done, 2'b01);
    chk("to_err", err, 2'b01);
    @(negedge clk);
    chk("to_err_single", err, 0);
`else
    n = 0;
`endif

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
